// File: rtl/io_char_buffer_if.sv
// Word- and character-side handshake bundle of the I/O character buffer.
// The buffer connects through the slave modport and the driving side through the master modport.
interface io_char_buffer_if #(
    parameter int CHAR_W  = 5,
    parameter int DIGIT_W = 4,
    parameter int DIGITS  = 7,
    parameter int DEPTH   = 4
);
    logic                          mode;
    logic [CHAR_W-1:0]             in_char;
    logic                          in_valid;
    logic                          in_ready;
    logic [DIGITS*DIGIT_W-1:0]     word_out;
    logic                          word_sign;
    logic                          word_ovf;
    logic                          word_valid;
    logic                          word_ready;
    logic [DIGITS*DIGIT_W-1:0]     word_in;
    logic                          word_in_sign;
    logic                          word_load;
    logic                          word_load_ready;
    logic [CHAR_W-1:0]             out_char;
    logic                          out_valid;
    logic                          out_ready;
    logic [$clog2(DEPTH+1)-1:0]    fifo_count;
    logic                          stop_seen;
    logic                          busy;

    modport slave (
        input  mode, in_char, in_valid, word_ready, word_in, word_in_sign, word_load, out_ready,
        output in_ready, word_out, word_sign, word_ovf, word_valid, word_load_ready,
               out_char, out_valid, fifo_count, stop_seen, busy
    );

    modport master (
        output mode, in_char, in_valid, word_ready, word_in, word_in_sign, word_load, out_ready,
        input  in_ready, word_out, word_sign, word_ovf, word_valid, word_load_ready,
               out_char, out_valid, fifo_count, stop_seen, busy
    );
endinterface

// File: rtl/io_char_buffer.sv
// Character FIFO shared by a digit assembler (input mode) and a word disassembler (output mode),
// successor to the G-15 OA/OB I/O character registers.
module io_char_buffer #(
    parameter int CHAR_W    = 5,
    parameter int DIGIT_W   = 4,
    parameter int DIGITS    = 7,
    parameter int DEPTH     = 4,
    parameter int TERM_CODE = 2
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              abort,
    io_char_buffer_if.slave   bus
);
    localparam int CODE_W = CHAR_W - 1;
    localparam int ACC_W  = DIGITS * DIGIT_W;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int PW     = $clog2(DEPTH);
    localparam int DCW    = $clog2(DIGITS + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_IN_HOLD  = 3'd1;
    localparam logic [2:0] ST_OUT_SIGN = 3'd2;
    localparam logic [2:0] ST_OUT_DIG  = 3'd3;
    localparam logic [2:0] ST_OUT_TERM = 3'd4;

    localparam logic [CODE_W-1:0] C_SIGN = CODE_W'(1);
    localparam logic [CODE_W-1:0] C_CR   = CODE_W'(2);
    localparam logic [CODE_W-1:0] C_TAB  = CODE_W'(3);
    localparam logic [CODE_W-1:0] C_STOP = CODE_W'(4);
    localparam logic [CODE_W-1:0] C_TERM = CODE_W'(TERM_CODE);

    localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
    localparam logic [DCW-1:0] DIG_MAX   = DCW'(DIGITS);
    localparam logic [DCW-1:0] DIG_LAST  = DCW'(DIGITS - 1);

    // Pointer increment that wraps at DEPTH, including non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        state_q, state_d;
    logic              mode_q, mode_d;
    logic [ACC_W-1:0]  acc_q, acc_d, oword_q, oword_d;
    logic [DCW-1:0]    dcount_q, dcount_d, odig_q, odig_d;
    logic              sign_q, sign_d, ovf_q, ovf_d, wvalid_q, wvalid_d, stop_q, stop_d;

    logic              push_s, pop_s, full_s, in_ready_s, out_valid_s;
    logic [CHAR_W-1:0] push_data_s, head_s;

    assign head_s      = mem_q[rd_ptr_q];
    assign full_s      = (count_q == FULL_CNT);
    assign in_ready_s  = ~mode_q & ~full_s;
    assign out_valid_s = mode_q & (count_q != {CW{1'b0}});

    // Next-state logic: assembler, disassembler, FIFO bookkeeping and the mode interlock.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        oword_d     = oword_q;
        dcount_d    = dcount_q;
        odig_d      = odig_q;
        sign_d      = sign_q;
        ovf_d       = ovf_q;
        wvalid_d    = wvalid_q;
        stop_d      = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        push_data_s = {CHAR_W{1'b0}};

        if (!mode_q) begin
            push_s      = bus.in_valid & in_ready_s;
            push_data_s = bus.in_char;
            if (state_q == ST_IN_HOLD) begin
                if (bus.word_ready) begin
                    acc_d    = {ACC_W{1'b0}};
                    dcount_d = {DCW{1'b0}};
                    sign_d   = 1'b0;
                    ovf_d    = 1'b0;
                    wvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_IN_HOLD;
                end
            end else if (state_q == ST_IDLE && count_q != {CW{1'b0}}) begin
                pop_s = 1'b1;
                if (head_s[CHAR_W-1]) begin
                    acc_d = (acc_q << DIGIT_W) | ACC_W'(head_s[DIGIT_W-1:0]);
                    if (dcount_q == DIG_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        dcount_d = dcount_q + DCW'(1);
                    end
                end else begin
                    case (head_s[CODE_W-1:0])
                        C_SIGN: sign_d = 1'b1;
                        C_CR, C_TAB: begin
                            wvalid_d = 1'b1;
                            state_d  = ST_IN_HOLD;
                        end
                        C_STOP: begin
                            stop_d = 1'b1;
                            // A bare STOP between fields only signals; it does not close a blank word.
                            if (dcount_q != {DCW{1'b0}} || sign_q) begin
                                wvalid_d = 1'b1;
                                state_d  = ST_IN_HOLD;
                            end else begin
                                state_d  = ST_IDLE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end else begin
                state_d = state_q;
            end
        end else begin
            pop_s = out_valid_s & bus.out_ready;
            case (state_q)
                ST_IDLE: begin
                    if (bus.word_load) begin
                        oword_d = bus.word_in;
                        odig_d  = {DCW{1'b0}};
                        state_d = bus.word_in_sign ? ST_OUT_SIGN : ST_OUT_DIG;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_OUT_SIGN: begin
                    if (!full_s) begin
                        push_s      = 1'b1;
                        push_data_s = {1'b0, C_SIGN};
                        state_d     = ST_OUT_DIG;
                    end else begin
                        state_d     = ST_OUT_SIGN;
                    end
                end
                ST_OUT_DIG: begin
                    if (!full_s) begin
                        push_s      = 1'b1;
                        push_data_s = {1'b1, CODE_W'(oword_q[ACC_W-1 -: DIGIT_W])};
                        oword_d     = oword_q << DIGIT_W;
                        if (odig_q == DIG_LAST) begin
                            odig_d  = {DCW{1'b0}};
                            state_d = ST_OUT_TERM;
                        end else begin
                            odig_d  = odig_q + DCW'(1);
                        end
                    end else begin
                        state_d = ST_OUT_DIG;
                    end
                end
                ST_OUT_TERM: begin
                    if (!full_s) begin
                        push_s      = 1'b1;
                        push_data_s = {1'b0, C_TERM};
                        state_d     = ST_IDLE;
                    end else begin
                        state_d     = ST_OUT_TERM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Direction may only flip when nothing is buffered, in flight or being started this cycle.
        if (state_q == ST_IDLE && state_d == ST_IDLE && count_q == {CW{1'b0}} &&
            dcount_q == {DCW{1'b0}} && !sign_q && !push_s) begin
            mode_d = bus.mode;
        end else begin
            mode_d = mode_q;
        end
    end

    // Control and datapath registers; abort clears everything exactly like reset.
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {PW{1'b0}};  rd_ptr_q <= {PW{1'b0}};  count_q <= {CW{1'b0}};
            state_q  <= ST_IDLE;     mode_q   <= 1'b0;
            acc_q    <= {ACC_W{1'b0}}; oword_q <= {ACC_W{1'b0}};
            dcount_q <= {DCW{1'b0}}; odig_q   <= {DCW{1'b0}};
            sign_q   <= 1'b0; ovf_q <= 1'b0; wvalid_q <= 1'b0; stop_q <= 1'b0;
        end else if (abort) begin
            wr_ptr_q <= {PW{1'b0}};  rd_ptr_q <= {PW{1'b0}};  count_q <= {CW{1'b0}};
            state_q  <= ST_IDLE;     mode_q   <= 1'b0;
            acc_q    <= {ACC_W{1'b0}}; oword_q <= {ACC_W{1'b0}};
            dcount_q <= {DCW{1'b0}}; odig_q   <= {DCW{1'b0}};
            sign_q   <= 1'b0; ovf_q <= 1'b0; wvalid_q <= 1'b0; stop_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  count_q <= count_d;
            state_q  <= state_d;   mode_q   <= mode_d;
            acc_q    <= acc_d;     oword_q  <= oword_d;
            dcount_q <= dcount_d;  odig_q   <= odig_d;
            sign_q   <= sign_d; ovf_q <= ovf_d; wvalid_q <= wvalid_d; stop_q <= stop_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= {CHAR_W{1'b0}};
        end else if (push_s && !abort) begin
            mem_q[wr_ptr_q] <= push_data_s;
        end
    end

    assign bus.in_ready        = in_ready_s;
    assign bus.out_valid       = out_valid_s;
    assign bus.out_char        = out_valid_s ? head_s : {CHAR_W{1'b0}};
    assign bus.fifo_count      = count_q;
    assign bus.word_out        = acc_q;
    assign bus.word_sign       = sign_q;
    assign bus.word_ovf        = ovf_q;
    assign bus.word_valid      = wvalid_q;
    assign bus.word_load_ready = mode_q & (state_q == ST_IDLE);
    assign bus.stop_seen       = stop_q;
    assign bus.busy            = (state_q != ST_IDLE) | (count_q != {CW{1'b0}}) | (dcount_q != {DCW{1'b0}});
endmodule

// File: tb/tb_io_char_buffer.sv
// Self-checking bench for io_char_buffer: table-driven input words, scoreboard-checked
// word and character outputs, and hand-written backpressure, interlock, reset and abort sequences.
module tb_io_char_buffer;
    logic CLOCK = 1'b0;
    logic rst   = 1'b0;
    logic abort = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   stop_cnt = 0;

    io_char_buffer_if #(.CHAR_W(5), .DIGIT_W(4), .DIGITS(7), .DEPTH(4)) bus_if ();

    io_char_buffer #(.CHAR_W(5), .DIGIT_W(4), .DIGITS(7), .DEPTH(4), .TERM_CODE(2)) dut (
        .CLOCK (CLOCK),
        .rst   (rst),
        .abort (abort),
        .bus   (bus_if)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed { logic o; logic s; logic [27:0] w; } wexp_t;
    typedef struct { logic [4:0] ch [9]; int n; logic [27:0] w; logic s; logic o; } vec_t;

    wexp_t      wq [$];
    logic [4:0] oq [$];
    vec_t       vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every word and character handshake against queued expectations.
    always @(negedge CLOCK) begin
        if (rst) begin
            if (bus_if.stop_seen) stop_cnt++;
            if (bus_if.word_valid && bus_if.word_ready) begin
                if (wq.size() == 0) chk("word_unexpected", 32'd1, 32'd0);
                else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("word", {2'b00, bus_if.word_ovf, bus_if.word_sign, bus_if.word_out}, {2'b00, e});
                end
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (oq.size() == 0) chk("char_unexpected", 32'd1, 32'd0);
                else chk("out_char", {27'd0, bus_if.out_char}, {27'd0, oq.pop_front()});
            end
        end
    end

    task automatic push_char(input logic [4:0] c);
        int n;
        n = 0;
        bus_if.in_char  = c;
        bus_if.in_valid = 1'b1;
        forever begin
            @(negedge CLOCK);
            if (bus_if.in_ready) break;
            n++;
            if (n > 200) begin
                chk("push_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge CLOCK); #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic load_word(input logic [27:0] w, input logic s);
        int n;
        n = 0;
        bus_if.word_in      = w;
        bus_if.word_in_sign = s;
        bus_if.word_load    = 1'b1;
        forever begin
            @(negedge CLOCK);
            if (bus_if.word_load_ready) break;
            n++;
            if (n > 200) begin
                chk("load_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge CLOCK); #1;
        bus_if.word_load = 1'b0;
    endtask

    task automatic drain(input string nm, input bit toggle);
        for (int i = 0; i < 300; i++) begin
            if (wq.size() == 0 && oq.size() == 0) break;
            @(posedge CLOCK); #1;
            if (toggle) bus_if.out_ready = ~bus_if.out_ready;
        end
        chk(nm, wq.size() + oq.size(), 32'd0);
    endtask

    task automatic wait_word_valid();
        for (int i = 0; i < 50 && !bus_if.word_valid; i++) begin
            @(posedge CLOCK); #1;
        end
        chk("word_valid_seen", {31'd0, bus_if.word_valid}, 32'd1);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_count"},     {29'd0, bus_if.fifo_count},    32'd0);
        chk({nm, "_out_valid"}, {31'd0, bus_if.out_valid},     32'd0);
        chk({nm, "_word_valid"},{31'd0, bus_if.word_valid},    32'd0);
        chk({nm, "_in_ready"},  {31'd0, bus_if.in_ready},      32'd1);
        chk({nm, "_busy"},      {31'd0, bus_if.busy},          32'd0);
        chk({nm, "_wlr"},       {31'd0, bus_if.word_load_ready}, 32'd0);
        chk({nm, "_out_char"},  {27'd0, bus_if.out_char},      32'd0);
        chk({nm, "_word_out"},  {4'd0, bus_if.word_out},       32'd0);
    endtask

    initial begin
        vecs[0] = '{ch: '{5'h11, 5'h12, 5'h13, 5'h01, 5'h02, 5'h00, 5'h00, 5'h00, 5'h00}, n: 5, w: 28'h0000123, s: 1'b1, o: 1'b0};
        vecs[1] = '{ch: '{5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18, 5'h02}, n: 9, w: 28'h2345678, s: 1'b0, o: 1'b1};
        vecs[2] = '{ch: '{5'h02, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, n: 1, w: 28'h0000000, s: 1'b0, o: 1'b0};
        vecs[3] = '{ch: '{5'h19, 5'h07, 5'h15, 5'h03, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, n: 4, w: 28'h0000095, s: 1'b0, o: 1'b0};
        vecs[4] = '{ch: '{5'h01, 5'h14, 5'h04, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, n: 3, w: 28'h0000004, s: 1'b1, o: 1'b0};
        vecs[5] = '{ch: '{5'h04, 5'h17, 5'h02, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, n: 3, w: 28'h0000007, s: 1'b0, o: 1'b0};

        bus_if.mode = 1'b0; bus_if.in_char = 5'd0; bus_if.in_valid = 1'b0;
        bus_if.word_ready = 1'b1; bus_if.word_in = 28'd0; bus_if.word_in_sign = 1'b0;
        bus_if.word_load = 1'b0; bus_if.out_ready = 1'b0;

        #12;
        chk_reset_state("reset");
        @(posedge CLOCK); #1;
        rst = 1'b1;
        @(posedge CLOCK); #1;

        // Table-driven input words.
        for (int v = 0; v < 6; v++) begin
            wq.push_back('{o: vecs[v].o, s: vecs[v].s, w: vecs[v].w});
            for (int k = 0; k < vecs[v].n; k++) push_char(vecs[v].ch[k]);
            drain("vec_drain", 1'b0);
            repeat (2) @(posedge CLOCK);
            #1;
            if (v == 0) chk("busy_after_word", {31'd0, bus_if.busy}, 32'd0);
        end

        // Backpressure with the assembler held, then wrap-around across three words.
        bus_if.word_ready = 1'b0;
        wq.push_back('{o: 1'b0, s: 1'b0, w: 28'h1});
        push_char(5'h11); push_char(5'h02);
        push_char(5'h12); push_char(5'h13); push_char(5'h14); push_char(5'h15);
        bus_if.in_char = 5'h16; bus_if.in_valid = 1'b1;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("bp_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        chk("bp_count", {29'd0, bus_if.fifo_count}, 32'd4);
        @(posedge CLOCK); #1;
        bus_if.word_ready = 1'b1;
        push_char(5'h16);
        wq.push_back('{o: 1'b0, s: 1'b0, w: 28'h23456});
        push_char(5'h02);
        wq.push_back('{o: 1'b0, s: 1'b1, w: 28'h78});
        push_char(5'h17); push_char(5'h18); push_char(5'h01); push_char(5'h03);
        drain("bp_drain", 1'b0);
        repeat (2) @(posedge CLOCK);
        #1;

        // Mode interlock: a partially assembled word blocks the switch to output.
        bus_if.word_ready = 1'b0;
        push_char(5'h13); push_char(5'h14);
        repeat (3) @(posedge CLOCK);
        #1;
        bus_if.mode = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("lock_wlr", {31'd0, bus_if.word_load_ready}, 32'd0);
        chk("lock_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        wq.push_back('{o: 1'b0, s: 1'b0, w: 28'h34});
        push_char(5'h02);
        wait_word_valid();
        chk("lock_hold_wlr", {31'd0, bus_if.word_load_ready}, 32'd0);
        bus_if.word_ready = 1'b1;
        drain("lock_drain", 1'b0);
        repeat (3) @(posedge CLOCK);
        #1;
        chk("lock_switched_wlr", {31'd0, bus_if.word_load_ready}, 32'd1);
        chk("lock_switched_in_ready", {31'd0, bus_if.in_ready}, 32'd0);

        // Output: signed word with a toggling device ready.
        oq.push_back(5'h01);
        for (int k = 0; k < 5; k++) oq.push_back(5'h10);
        oq.push_back(5'h1A); oq.push_back(5'h15); oq.push_back(5'h02);
        load_word(28'h00000A5, 1'b1);
        drain("out1_drain", 1'b1);
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        chk("out1_wlr", {31'd0, bus_if.word_load_ready}, 32'd1);
        chk("out1_out_valid", {31'd0, bus_if.out_valid}, 32'd0);

        // Output: unsigned word, no sign character, device always ready.
        bus_if.out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) oq.push_back(5'h10 | 5'(k));
        oq.push_back(5'h02);
        load_word(28'h1234567, 1'b0);
        drain("out2_drain", 1'b0);
        repeat (2) @(posedge CLOCK);
        #1;
        chk("out2_count", {29'd0, bus_if.fifo_count}, 32'd0);

        // Asynchronous reset while digits are being emitted.
        bus_if.out_ready = 1'b0;
        load_word(28'h1234567, 1'b1);
        repeat (3) @(posedge CLOCK);
        #3;
        chk("pre_rst_busy", {31'd0, bus_if.busy}, 32'd1);
        rst = 1'b0;
        bus_if.mode = 1'b0;
        #1;
        chk_reset_state("rst_mid_out");
        @(posedge CLOCK); #1;
        rst = 1'b1;

        // Synchronous abort while a word is held.
        bus_if.word_ready = 1'b0;
        push_char(5'h11); push_char(5'h02); push_char(5'h12);
        wait_word_valid();
        abort = 1'b1;
        @(posedge CLOCK); #1;
        abort = 1'b0;
        chk_reset_state("abort_hold");

        // Normal operation resumes after abort.
        bus_if.word_ready = 1'b1;
        wq.push_back('{o: 1'b0, s: 1'b0, w: 28'h5});
        push_char(5'h15); push_char(5'h02);
        drain("post_abort_drain", 1'b0);
        repeat (2) @(posedge CLOCK);
        #1;
        chk("stop_pulses", stop_cnt, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
